// File: rtl/bram_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bram_rr_arbiter_pkg
// Shared defaults for the round-robin BRAM arbiter and the helper that sizes
// requester ids.
//   D_DEFAULT : RAM data width in bits
//   A_DEFAULT : RAM address width in bits (depth 2**A)
//   N_DEFAULT : number of requesters (legal 2..8)
//   clog2(n)  : bits needed to hold an id in 0..n-1 (never less than 1)
// ----------------------------------------------------------------------------
package bram_rr_arbiter_pkg;

    localparam int D_DEFAULT = 16;
    localparam int A_DEFAULT = 10;
    localparam int N_DEFAULT = 4;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rams_sdp_rf.sv
// ----------------------------------------------------------------------------
// rams_sdp_rf
// Simple dual-port RAM, one write port (A) and one synchronous read port (B)
// on a single clock. Read-first: a read and write of the same address in the
// same cycle returns the old word.
//   clk   : clock
//   ena   : port A enable
//   wea   : port A write enable (qualified by ena)
//   addra : write address
//   dia   : write data
//   enb   : port B enable, loads dob on the next rising edge
//   addrb : read address
//   dob   : registered read data
// ----------------------------------------------------------------------------
module rams_sdp_rf #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          ena,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dia,
    input  logic          enb,
    input  logic [AW-1:0] addrb,
    output logic [DW-1:0] dob
);

    logic [DW-1:0] ram [2**AW];

    // NOTE: the array has no reset; clearing every word would stop it mapping
    // onto block RAM. Consumers gate dob with their own valid bit instead.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make the read sample the word as it
        // was before this edge's write, which is what gives read-first.
        if (ena && wea) begin
            ram[addra] <= dia;
        end
        if (enb) begin
            dob <= ram[addrb];
        end
    end

endmodule

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Round-robin picker: grants the first candidate found searching upward from
// ptr, wrapping modulo N.
//   cand  : candidate vector, one bit per requester
//   ptr   : search start position
//   grant : one-hot grant (all zero when no candidate)
//   idx   : index of the granted requester (0 when no candidate)
//   any   : a grant was issued this cycle
// ----------------------------------------------------------------------------
module rr_pick
    import bram_rr_arbiter_pkg::*;
#(
    parameter  int N  = N_DEFAULT,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so paths
        // with no candidate still assign everything and no latch is inferred.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int off = 0; off < N; off++) begin
            j = int'(ptr) + off;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && cand[j]) begin
                grant[j] = 1'b1;
                idx      = IW'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// bram_rr_arbiter
// Shares one simple dual-port RAM between N requesters. Writes and reads are
// arbitrated independently with separate round-robin pointers, so one write
// and one read can be accepted in the same cycle. Reads return one cycle
// after acceptance on a one-hot rsp_valid with shared rsp_rdata.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req_valid : per-requester request valid
//   req_we    : per-requester request type (1 write, 0 read)
//   req_addr  : per-requester address, requester i at [i*A +: A]
//   req_wdata : per-requester write data, requester i at [i*D +: D]
//   req_ready : per-requester accept strobe (combinational)
//   rsp_valid : one-hot read response strobe
//   rsp_rdata : read data, zero when rsp_valid is zero
// ----------------------------------------------------------------------------
module bram_rr_arbiter
    import bram_rr_arbiter_pkg::*;
#(
    parameter int D = D_DEFAULT,
    parameter int A = A_DEFAULT,
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N-1:0]   req_we,
    input  logic [N*A-1:0] req_addr,
    input  logic [N*D-1:0] req_wdata,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   rsp_valid,
    output logic [D-1:0]   rsp_rdata
);

    localparam int IW = clog2(N);

    logic [IW-1:0] wr_ptr, rd_ptr;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [N-1:0]  wr_cand, rd_cand;
    logic [N-1:0]  wr_grant, rd_grant;
    logic          wr_any, rd_any;
    logic [A-1:0]  wr_addr, rd_addr;
    logic [D-1:0]  wr_data, ram_dout;
    logic          rsp_vld_q;
    logic [IW-1:0] rsp_id_q;

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] k);
        return (k == IW'(N - 1)) ? '0 : k + 1'b1;
    endfunction

    // Candidates are masked by rst_n so nothing is granted (and nothing can
    // be accepted) while reset is held, including mid-cycle assertion.
    assign wr_cand = req_valid &  req_we & {N{rst_n}};
    assign rd_cand = req_valid & ~req_we & {N{rst_n}};

    rr_pick #(.N(N)) u_wr_pick (
        .cand  (wr_cand),
        .ptr   (wr_ptr),
        .grant (wr_grant),
        .idx   (wr_idx),
        .any   (wr_any)
    );

    rr_pick #(.N(N)) u_rd_pick (
        .cand  (rd_cand),
        .ptr   (rd_ptr),
        .grant (rd_grant),
        .idx   (rd_idx),
        .any   (rd_any)
    );

    assign req_ready = wr_grant | rd_grant;

    assign wr_addr = req_addr[wr_idx*A +: A];
    assign wr_data = req_wdata[wr_idx*D +: D];
    assign rd_addr = req_addr[rd_idx*A +: A];

    rams_sdp_rf #(.DW(D), .AW(A)) u_ram (
        .clk   (clk),
        .ena   (wr_any),
        .wea   (1'b1),
        .addra (wr_addr),
        .dia   (wr_data),
        .enb   (rd_any),
        .addrb (rd_addr),
        .dob   (ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= '0;
        end else begin
            if (wr_any) begin
                wr_ptr <= ptr_after(wr_idx);
            end
            if (rd_any) begin
                rd_ptr   <= ptr_after(rd_idx);
                rsp_id_q <= rd_idx;
            end
            rsp_vld_q <= rd_any;
        end
    end

    // Only the id and a valid bit are registered; the data is the RAM's own
    // output register, gated to zero when no response is pending.
    always_comb begin
        rsp_valid = '0;
        if (rsp_vld_q) begin
            rsp_valid[rsp_id_q] = 1'b1;
        end
    end

    assign rsp_rdata = rsp_vld_q ? ram_dout : '0;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
module tb_bram_rr_arbiter;

    localparam int D = 16;
    localparam int A = 10;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_we;
    logic [N*A-1:0] req_addr;
    logic [N*D-1:0] req_wdata;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [D-1:0]   rsp_rdata;

    bram_rr_arbiter #(.D(D), .A(A), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] we;
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rsp;
    } vec_t;

    vec_t vecs [12];

    // reference model state for the random phase
    logic [D-1:0] mem_m [2**A];
    logic [A-1:0] addr_set [8];
    logic         pend [N];
    logic         pwe  [N];
    logic [A-1:0] pad  [N];
    logic [D-1:0] pdat [N];
    int           wait_c [N];
    int           wp, rp, wg, rg;
    logic [N-1:0] exp_ready, exp_rv;
    logic [D-1:0] exp_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [A-1:0] a, input logic [D-1:0] d);
        req_valid[i]       = 1'b1;
        req_we[i]          = we;
        req_addr[i*A +: A] = a;
        req_wdata[i*D +: D] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // check the current cycle's ready and response, then advance one cycle
    task automatic cyc(input string tag, input logic [N-1:0] rdy, input logic [N-1:0] rv,
                       input logic [D-1:0] rd);
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(rv));
        check({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(rd));
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // arbitration table, applied from the post-reset state (both pointers 0)
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0001, 4'b0000};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0010, 4'b0001};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0100, 4'b0010};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1000, 4'b0100};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0001, 4'b1000};
        vecs[5]  = '{4'b1111, 4'b1111, 4'b0001, 4'b0001};
        vecs[6]  = '{4'b0101, 4'b0001, 4'b0101, 4'b0000};
        vecs[7]  = '{4'b1001, 4'b0001, 4'b1001, 4'b0100};
        vecs[8]  = '{4'b1111, 4'b1010, 4'b0011, 4'b1000};
        vecs[9]  = '{4'b1111, 4'b1010, 4'b1100, 4'b0001};
        vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
        vecs[11] = '{4'b1111, 4'b1010, 4'b0011, 4'b0000};

        addr_set = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h3FE, 10'h3FF, 10'h200, 10'h155};

        // ---- reset with every requester asking to read
        rst_n = 1'b0;
        clear_reqs();
        req_valid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.ready", 32'(req_ready), 32'h0);
        check("reset.rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset.rsp_rdata", 32'(rsp_rdata), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        clear_reqs();

        // ---- table-driven arbitration
        for (int r = 0; r < 12; r++) begin
            clear_reqs();
            for (int i = 0; i < N; i++) begin
                if (vecs[r].valid[i]) begin
                    set_req(i, vecs[r].we[i], A'(256 + i), D'(r * 16 + i));
                end
            end
            @(negedge clk);
            check($sformatf("vec%0d.ready", r), 32'(req_ready), 32'(vecs[r].exp_ready));
            check($sformatf("vec%0d.rsp_valid", r), 32'(rsp_valid), 32'(vecs[r].exp_rsp));
            next_cycle();
        end
        clear_reqs();
        @(negedge clk);
        check("vec_flush.rsp_valid", 32'(rsp_valid), 32'h1);
        next_cycle();

        // ---- single write then read back
        clear_reqs(); set_req(0, 1'b1, 10'h003, 16'h00A5);
        cyc("wr_a5", 4'b0001, 4'b0000, 16'h0000);
        clear_reqs(); set_req(0, 1'b0, 10'h003, 16'h0000);
        cyc("rd_a5", 4'b0001, 4'b0000, 16'h0000);
        clear_reqs();
        cyc("rsp_a5", 4'b0000, 4'b0001, 16'h00A5);

        // ---- same-cycle read and write to one address returns old data
        clear_reqs(); set_req(0, 1'b1, 10'h010, 16'hBEEF);
        cyc("wr_beef", 4'b0001, 4'b0000, 16'h0000);
        clear_reqs(); set_req(1, 1'b1, 10'h010, 16'h1234); set_req(2, 1'b0, 10'h010, 16'h0000);
        cyc("rw_same", 4'b0110, 4'b0000, 16'h0000);
        clear_reqs(); set_req(2, 1'b0, 10'h010, 16'h0000);
        cyc("reread", 4'b0100, 4'b0100, 16'hBEEF);
        clear_reqs();
        cyc("rsp_new", 4'b0000, 4'b0100, 16'h1234);

        // ---- address wrap and back-to-back reads from one requester
        clear_reqs(); set_req(3, 1'b1, 10'h3FF, 16'h5A5A);
        cyc("wr_3ff", 4'b1000, 4'b0000, 16'h0000);
        clear_reqs(); set_req(2, 1'b1, 10'h000, 16'hC3C3);
        cyc("wr_000", 4'b0100, 4'b0000, 16'h0000);
        clear_reqs(); set_req(1, 1'b0, 10'h3FF, 16'h0000);
        cyc("rd_3ff", 4'b0010, 4'b0000, 16'h0000);
        clear_reqs(); set_req(1, 1'b0, 10'h000, 16'h0000);
        cyc("rd_000", 4'b0010, 4'b0010, 16'h5A5A);
        clear_reqs();
        cyc("rsp_000", 4'b0000, 4'b0010, 16'hC3C3);
        cyc("idle", 4'b0000, 4'b0000, 16'h0000);

        // ---- reset pulsed while a response is pending
        clear_reqs(); set_req(2, 1'b0, 10'h010, 16'h0000);
        cyc("rd_pre_rst", 4'b0100, 4'b0000, 16'h0000);
        check("pre_rst.rsp_valid", 32'(rsp_valid), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst.rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_rst.rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("mid_rst.ready", 32'(req_ready), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        clear_reqs();
        cyc("post_rst", 4'b0000, 4'b0000, 16'h0000);
        clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, A'(768 + i), D'(16'h7000 + i));
        cyc("wr_ptr0", 4'b0001, 4'b0000, 16'h0000);
        clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, A'(768 + i), 16'h0000);
        cyc("rd_ptr0", 4'b0001, 4'b0000, 16'h0000);
        clear_reqs();
        cyc("rsp_ptr0", 4'b0000, 4'b0001, 16'h7000);

        // ---- random traffic against the reference model
        for (int k = 0; k < 8; k++) begin
            mem_m[addr_set[k]] = D'(16'h1000 + k * 16'h0111);
            clear_reqs(); set_req(0, 1'b1, addr_set[k], mem_m[addr_set[k]]);
            @(negedge clk);
            check("preload.ready", 32'(req_ready), 32'h1);
            next_cycle();
        end
        // RAM contents must survive this reset
        clear_reqs();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;

        wp = 0; rp = 0;
        exp_rv = '0; exp_rd = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; wait_c[i] = 0;
        end

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 9) < 7)) begin
                    pend[i]   = 1'b1;
                    pwe[i]    = 1'($urandom_range(0, 1));
                    pad[i]    = addr_set[$urandom_range(0, 7)];
                    pdat[i]   = D'($urandom);
                    wait_c[i] = 0;
                end
            end
            clear_reqs();
            for (int i = 0; i < N; i++) begin
                if (pend[i]) set_req(i, pwe[i], pad[i], pdat[i]);
            end
            @(negedge clk);

            // first pending requester of each class at or after its pointer
            wg = -1; rg = -1;
            for (int off = 0; off < N; off++) begin
                if (wg < 0 && pend[(wp + off) % N] && pwe[(wp + off) % N]) wg = (wp + off) % N;
                if (rg < 0 && pend[(rp + off) % N] && !pwe[(rp + off) % N]) rg = (rp + off) % N;
            end
            exp_ready = '0;
            if (wg >= 0) exp_ready[wg] = 1'b1;
            if (rg >= 0) exp_ready[rg] = 1'b1;

            check("rand.ready", 32'(req_ready), 32'(exp_ready));
            check("rand.rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("rand.rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));

            exp_rv = '0; exp_rd = '0;
            if (rg >= 0) begin
                exp_rv[rg] = 1'b1;
                exp_rd     = mem_m[pad[rg]];
                rp         = (rg + 1) % N;
            end
            if (wg >= 0) begin
                mem_m[pad[wg]] = pdat[wg];
                wp             = (wg + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    wait_c[i]++;
                    if (i == wg || i == rg) begin
                        check($sformatf("rand.wait%0d_le_%0d", i, N), 32'(wait_c[i] <= N), 32'h1);
                        pend[i] = 1'b0;
                    end
                end
            end
            next_cycle();
        end
        clear_reqs();
        @(negedge clk);
        check("rand_end.rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rand_end.rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
